// File: rtl/pwm_sine_gen.sv
// Fixed-period PWM generator with boundary-synchronised width updates
// and an IDLE/RUN/DRAIN run controller.
module pwm_sine_gen #(
   parameter int unsigned PERIOD = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [31:0] width,
   input  logic        width_load,
   output logic        pwm_out,
   output logic        period_start,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [31:0] PER  = 32'(PERIOD);
   localparam logic [31:0] LAST = 32'(PERIOD - 1);

   state_t      state, state_nx;
   logic [31:0] cnt, cnt_nx;
   logic [31:0] pending, active, active_nx, src;
   logic        boundary, last, busy_nx;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      boundary = 1'b0;
      last     = (cnt == LAST);
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (enable) begin
               state_nx = RUN;
               boundary = 1'b1;
            end
         end
         RUN: begin
            // enable dropping on the final count goes straight to IDLE: no extra drain period
            if (last) begin
               cnt_nx = '0;
               if (enable) boundary = 1'b1;
               else        state_nx = IDLE;
            end else begin
               cnt_nx = cnt + 32'd1;
               if (!enable) state_nx = DRAIN;
            end
         end
         DRAIN: begin
            cnt_nx = last ? '0 : cnt + 32'd1;
            if (enable) begin
               state_nx = RUN;
               boundary = last;
            end else if (last) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase

      src       = width_load ? width : pending;
      active_nx = boundary ? ((src > PER) ? PER : src) : active;
      busy_nx   = (state_nx != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         pending      <= '0;
         active       <= '0;
         pwm_out      <= 1'b0;
         period_start <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         active       <= active_nx;
         if (width_load) pending <= width;
         pwm_out      <= busy_nx && (cnt_nx < active_nx);
         period_start <= (state_nx == RUN) && (cnt_nx == '0);
         busy         <= busy_nx;
      end
   end

endmodule
